// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: sequential req/ack fetches into a DEPTH-entry ring, redirect flush, halt stop.
// Optional same-cycle ack-to-core bypass when the queue is empty: define PREFETCH_BYPASS_EN.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic accept, bypass, push, pop, head_valid;

  assign head_valid = (count_q != '0);
  assign accept     = (state_q == S_WAIT) && imem_ack && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = (count_q == '0) && accept;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that the core takes this cycle never enters the queue.
  assign push = accept && !(bypass && !stall);
  assign pop  = head_valid && !stall;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        // Request is held low while rst is asserted so the reset outputs are quiet.
        if (!rst && !halted_q && (count_q < DEPTH_C) && !redirect_valid) begin
          imem_req = 1'b1;
          addr_d   = fetch_pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack)            state_d = S_IDLE;
        else if (redirect_valid) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (imem_rdata[6:0] == 7'b0000000) halted_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      halted_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      halted_q   <= halted_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= addr_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    inst_valid = head_valid;
    inst_out   = head_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
    inst_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    if (bypass) begin
      inst_valid = 1'b1;
      inst_out   = imem_rdata;
      inst_pc    = addr_q;
    end
  end

  assign fetch_halted = halted_q;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_inst_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst_out, inst_pc, imem_addr, imem_rdata;
  logic        inst_valid, imem_req, imem_ack, fetch_halted;

  inst_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed pattern with opcode 0x13, plus per-test overrides.
  logic [31:0] mem_over [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return {a[26:2] ^ 25'h0A5A5A5, 7'h13};
  endfunction

  // Reference model: the queue contents and the fetch bookkeeping the core would see.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch, m_addr;
  bit          m_halted, m_busy, m_discard;

  int age;     // cycles the current request has been visible to memory
  int n_done;  // requests completed by a delivered ack
  logic [31:0] s_inst, s_pc, s_addr;
  logic        s_valid, s_req, s_halt;

  task automatic model_reset();
    m_q.delete();
    m_fetch = 32'h0; m_addr = 32'h0;
    m_halted = 0; m_busy = 0; m_discard = 0;
    age = 0;
  endtask

  task automatic run_cycle(input bit st, input bit rv, input logic [31:0] rpc, input bit ak);
    bit byp_now, exp_req, issue;
    logic [31:0] exp_addr, exp_inst, exp_pc;
    bit exp_valid;
    stall = st; redirect_valid = rv; redirect_pc = rpc; imem_ack = ak;
    imem_rdata = ak ? mem_word(imem_addr) : $urandom();
    #1;
    s_inst = inst_out; s_pc = inst_pc; s_valid = inst_valid;
    s_req = imem_req; s_addr = imem_addr; s_halt = fetch_halted;

    byp_now  = BYP && (m_q.size() == 0) && m_busy && !m_discard && ak && !rv;
    exp_req  = m_busy || (!m_halted && m_q.size() < DEPTH && !rv);
    exp_addr = m_busy ? m_addr : m_fetch;
    if (byp_now) begin
      exp_valid = 1; exp_inst = imem_rdata; exp_pc = m_addr;
    end else if (m_q.size() > 0) begin
      exp_valid = 1; exp_inst = m_q[0].inst; exp_pc = m_q[0].pc;
    end else begin
      exp_valid = 0; exp_inst = NOP; exp_pc = 32'h0;
    end
    check("imem_req", s_req, exp_req);
    check("imem_addr", s_addr, exp_addr);
    check("inst_valid", s_valid, exp_valid);
    check("inst_out", s_inst, exp_inst);
    check("inst_pc", s_pc, exp_pc);
    check("fetch_halted", s_halt, m_halted);

    issue = !m_busy && exp_req;
    if (rv) begin
      m_q.delete();
      m_fetch = rpc; m_halted = 0;
      if (m_busy && ak) begin m_busy = 0; m_discard = 0; end
      else if (m_busy)  m_discard = 1;
    end else begin
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (m_busy && ak) begin
        if (!m_discard) begin
          if (!(byp_now && !st)) m_q.push_back('{pc: m_addr, inst: imem_rdata});
          m_fetch = m_fetch + 32'd4;
          if (imem_rdata[6:0] == 7'b0) m_halted = 1;
        end
        m_busy = 0; m_discard = 0;
      end
      if (issue) begin m_busy = 1; m_addr = m_fetch; m_discard = 0; end
    end

    if (s_req && ak && age >= 1) begin n_done++; age = 0; end
    else if (s_req) age++;
    else age = 0;
    @(posedge clk); #1;
  endtask

  // Memory that acknowledges once a request has been visible for lat cycles.
  task automatic run_auto(input bit st, input bit rv, input logic [31:0] rpc, input int lat);
    run_cycle(st, rv, rpc, imem_req && (age >= lat));
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst_out, NOP);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_halted", fetch_halted, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  typedef struct {
    logic stall, ack; logic [31:0] rdata;
    logic req; logic [31:0] addr; logic valid; logic [31:0] pc, inst;
  } vec_t;
  vec_t tbl [7];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.stall = 0; v.ack = ack; v.rdata = rdata; v.req = 1; v.addr = addr;
    v.valid = valid; v.pc = valid ? pc : 32'h0; v.inst = valid ? inst : NOP;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] popped[$];
    bit found;

    // Sequential fetch with 1-cycle memory, core consuming every cycle.
    tbl[0] = mk(0, 32'h0,           32'h0, 0,    32'h0, NOP);
    tbl[1] = mk(1, mem_word(32'h0), 32'h0, BYP,  32'h0, mem_word(32'h0));
    tbl[2] = mk(0, 32'h0,           32'h4, !BYP, 32'h0, mem_word(32'h0));
    tbl[3] = mk(1, mem_word(32'h4), 32'h4, BYP,  32'h4, mem_word(32'h4));
    tbl[4] = mk(0, 32'h0,           32'h8, !BYP, 32'h4, mem_word(32'h4));
    tbl[5] = mk(1, mem_word(32'h8), 32'h8, BYP,  32'h8, mem_word(32'h8));
    tbl[6] = mk(0, 32'h0,           32'hC, !BYP, 32'h8, mem_word(32'h8));

    do_reset();
    for (int i = 0; i < 7; i++) begin
      stall = tbl[i].stall; redirect_valid = 0; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      #1;
      check($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].valid);
      check($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
      check($sformatf("tbl%0d_inst", i), inst_out, tbl[i].inst);
      @(posedge clk); #1;
    end

    // Full queue under stall with memory always acknowledging.
    do_reset();
    n_done = 0;
    for (int i = 0; i < 10; i++) run_cycle(1, 0, 0, 1);
    check("full_completed", n_done, 4);
    check("full_req_low", s_req, 0);
    check("full_head_pc", s_pc, 32'h0);
    for (int i = 0; i < 12; i++) begin
      run_cycle(0, 0, 0, 1);
      if (s_valid) popped.push_back(s_pc);
    end
    check("drain_count_ok", popped.size() >= 4, 1);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check($sformatf("drain_pc%0d", i), popped[i], 32'(i * 4));

    // Redirect while waiting on 0x8 with a late ack: data dropped.
    do_reset();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h8 && age == 0) begin found = 1; break; end
      run_auto(0, 0, 0, 1);
    end
    check("disc_reach_0x8", found, 1);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 1, 32'h100, 0);
    run_cycle(0, 0, 0, 0);
    check("disc_hold_req", s_req, 1);
    check("disc_hold_addr", s_addr, 32'h8);
    run_cycle(0, 0, 0, 1);
    check("disc_late_valid", s_valid, 0);
    check("disc_late_inst", s_inst, NOP);
    run_cycle(0, 0, 0, 0);
    check("disc_next_req", s_req, 1);
    check("disc_next_addr", s_addr, 32'h100);
    check("disc_next_valid", s_valid, 0);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      run_auto(0, 0, 0, 1);
      found = s_valid;
    end
    check("disc_new_pc", s_pc, 32'h100);

    // Redirect coincides with ack and pop while two entries are queued.
    do_reset();
    for (int i = 0; i < 5; i++) run_auto(1, 0, 0, 1);
    check("coinc_two_queued_head", s_pc, 32'h0);
    run_cycle(0, 1, 32'h100, 1);
    run_cycle(0, 0, 0, 0);
    check("coinc_empty", s_valid, 0);
    check("coinc_req", s_req, 1);
    check("coinc_fetch_pc", s_addr, 32'h100);

    // Halt word at 0x10 stops fetching until a redirect.
    mem_over[32'h10] = 32'h0;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_auto(0, 0, 0, 1);
      found = fetch_halted;
    end
    check("halt_reached", found, 1);
    for (int i = 0; i < 4; i++) begin
      run_auto(0, 0, 0, 1);
      check("halt_no_req", s_req, 0);
    end
    run_cycle(0, 1, 32'h40, 0);
    run_cycle(0, 0, 0, 0);
    check("halt_cleared", s_halt, 0);
    check("halt_resume_req", s_req, 1);
    check("halt_resume_addr", s_addr, 32'h40);
    mem_over.delete(32'h10);

    // Empty-queue ack: same-cycle delivery with bypass, next cycle without.
    mem_over[32'h20] = 32'h0010_0093;
    do_reset();
    run_cycle(0, 1, 32'h20, 0);
    run_cycle(0, 0, 0, 0);
    check("byp_req_addr", s_addr, 32'h20);
    run_cycle(0, 0, 0, 1);
    check("byp_ack_valid", s_valid, BYP);
    check("byp_ack_inst", s_inst, BYP ? 32'h0010_0093 : NOP);
    check("byp_ack_pc", s_pc, BYP ? 32'h20 : 32'h0);
    run_cycle(0, 0, 0, 0);
    check("byp_next_valid", s_valid, !BYP);
    check("byp_next_inst", s_inst, BYP ? NOP : 32'h0010_0093);
    check("byp_next_pc", s_pc, BYP ? 32'h0 : 32'h20);
    mem_over.delete(32'h20);

    // Asynchronous reset mid-request; a late ack afterwards is ignored.
    do_reset();
    run_cycle(0, 0, 0, 0);
    #2 rst = 1;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_addr", imem_addr, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 0);
    check("midrst_late_ack", s_valid, 0);

    // Randomized traffic with redirects, stalls, variable latency and a halt word.
    mem_over[32'h238] = 32'h0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom % 10) < 3, ($urandom % 25) == 0,
                32'h200 + 32'(4 * $urandom_range(0, 24)),
                imem_req && age >= 1 && ($urandom % 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
